// File: rtl/demux1x8_32bit_seq_if.sv
// Bus bundle for the 1-to-8 word distributor: producer handshake, frame control and slot outputs.
// dbg_state mirrors the FSM (0 = FILL, 1 = HOLD) so checkers can bind to it.
interface demux1x8_32bit_seq_if;
    logic [31:0] in_data;
    logic [2:0]  in_sel;
    logic        mode;
    logic        in_valid;
    logic        in_ready;
    logic        clear;
    logic        frame_ack;
    logic [31:0] a, b, c, d, e, f, g, h;
    logic [7:0]  filled;
    logic [2:0]  ptr;
    logic        frame_done;
    logic        dbg_state;

    modport master (
        output in_data, in_sel, mode, in_valid, clear, frame_ack,
        input  in_ready, a, b, c, d, e, f, g, h, filled, ptr, frame_done, dbg_state
    );

    modport slave (
        input  in_data, in_sel, mode, in_valid, clear, frame_ack,
        output in_ready, a, b, c, d, e, f, g, h, filled, ptr, frame_done, dbg_state
    );
endinterface

// File: rtl/demux1x8_32bit_seq.sv
// Sequential 1-to-8 word distributor: fills slots a..h, then holds the frame until frame_ack.
// Optional DEMUX_ZERO_ON_ACK_EN: zero slot data when an acknowledged frame returns to FILL.
module demux1x8_32bit_seq (
    input  logic                    clk,
    input  logic                    reset_n,
    demux1x8_32bit_seq_if.slave     bus
);
    // Handshake: a beat transfers on a rising edge where in_valid && in_ready;
    // in_ready depends only on state and clear, never on in_valid.
    typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [31:0] slot_q [8];
    logic [7:0]  filled_q, filled_d;
    logic [2:0]  ptr_q, ptr_d;
    logic [2:0]  target;
    logic [7:0]  onehot;
    logic        ready;
    logic        accept;
    logic        frame_done_q;

    always_comb begin
        ready    = (state_q == FILL) && !bus.clear;
        accept   = bus.in_valid && ready;
        target   = bus.mode ? ptr_q : bus.in_sel;
        onehot   = 8'b1 << target;
        state_d  = state_q;
        filled_d = filled_q;
        ptr_d    = ptr_q;
        if (bus.clear) begin
            state_d  = FILL;
            filled_d = 8'h00;
            ptr_d    = 3'd0;
        end else begin
            case (state_q)
                FILL: begin
                    if (accept) begin
                        filled_d = filled_q | onehot;
                        if (bus.mode) ptr_d = ptr_q + 3'd1;
                        if (filled_d == 8'hFF) state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (bus.frame_ack) begin
                        state_d  = FILL;
                        filled_d = 8'h00;
                        ptr_d    = 3'd0;
                    end
                end
                default: state_d = FILL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= FILL;
            filled_q     <= 8'h00;
            ptr_q        <= 3'd0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            filled_q     <= filled_d;
            ptr_q        <= ptr_d;
            frame_done_q <= (state_q == FILL) && (state_d == HOLD);
        end
    end

`ifdef DEMUX_ZERO_ON_ACK_EN
    logic restart;
    assign restart = (state_q == HOLD) && bus.frame_ack && !bus.clear;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) slot_q[i] <= 32'd0;
        end else if (restart) begin
            for (int i = 0; i < 8; i++) slot_q[i] <= 32'd0;
        end else if (accept) begin
            slot_q[target] <= bus.in_data;
        end
    end
`else
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) slot_q[i] <= 32'd0;
        end else if (accept) begin
            slot_q[target] <= bus.in_data;
        end
    end
`endif

    assign bus.in_ready   = ready;
    assign bus.a          = slot_q[0];
    assign bus.b          = slot_q[1];
    assign bus.c          = slot_q[2];
    assign bus.d          = slot_q[3];
    assign bus.e          = slot_q[4];
    assign bus.f          = slot_q[5];
    assign bus.g          = slot_q[6];
    assign bus.h          = slot_q[7];
    assign bus.filled     = filled_q;
    assign bus.ptr        = ptr_q;
    assign bus.frame_done = frame_done_q;
    assign bus.dbg_state  = (state_q == HOLD);
endmodule

// File: tb/tb_demux1x8_32bit_seq.sv
// Directed testbench for demux1x8_32bit_seq: auto/addressed fill, ack, clear, wrap and async reset.
module tb_demux1x8_32bit_seq;
`ifdef DEMUX_ZERO_ON_ACK_EN
    localparam bit ZERO_ON_ACK = 1'b1;
`else
    localparam bit ZERO_ON_ACK = 1'b0;
`endif

    logic clk;
    logic reset_n;
    int   tests_run;
    int   tests_failed;
    logic [31:0] exp_q[$];

    demux1x8_32bit_seq_if bus();

    demux1x8_32bit_seq dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic m, input logic [2:0] s, input logic [31:0] dat);
        bus.mode     = m;
        bus.in_sel   = s;
        bus.in_data  = dat;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic ack_cycle();
        bus.frame_ack = 1'b1;
        @(posedge clk);
        #1;
        bus.frame_ack = 1'b0;
    endtask

    function automatic logic [31:0] slot_val(input int i);
        case (i)
            0: return bus.a;
            1: return bus.b;
            2: return bus.c;
            3: return bus.d;
            4: return bus.e;
            5: return bus.f;
            6: return bus.g;
            default: return bus.h;
        endcase
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 32'd0;
        bus.in_sel    = 3'd0;
        bus.mode      = 1'b0;
        bus.clear     = 1'b0;
        bus.frame_ack = 1'b0;
        #12;
        for (int i = 0; i < 8; i++) begin
            tests_run++;
            if (slot_val(i) !== 32'd0) begin
                $display("FAIL reset_slot%0d: got %h expected 0", i, slot_val(i)); tests_failed++;
            end
        end
        tests_run++;
        if (bus.filled !== 8'h00 || bus.ptr !== 3'd0 || bus.frame_done !== 1'b0) begin
            $display("FAIL reset_regs: filled=%h ptr=%0d frame_done=%b expected 00/0/0",
                     bus.filled, bus.ptr, bus.frame_done); tests_failed++;
        end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        tests_run++;
        if (bus.in_ready !== 1'b1 || bus.dbg_state !== 1'b0) begin
            $display("FAIL reset_ready: in_ready=%b state=%b expected 1/0", bus.in_ready, bus.dbg_state);
            tests_failed++;
        end
    endtask

    task automatic test_auto_fill();
        logic [31:0] vals [8];
        logic [31:0] exp;
        vals = '{32'd123, 32'd456, 32'd789, 32'd101112, 32'd131415, 32'd161718, 32'd192021, 32'd222324};
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back(vals[k]);
            send(1'b1, 3'd0, vals[k]);
            tests_run++;
            if (bus.frame_done !== (k == 7)) begin
                $display("FAIL auto_frame_done beat%0d: got %b expected %b", k, bus.frame_done, k == 7);
                tests_failed++;
            end
        end
        for (int i = 0; i < 8; i++) begin
            exp = exp_q.pop_front();
            tests_run++;
            if (slot_val(i) !== exp) begin
                $display("FAIL auto_slot%0d: got %0d expected %0d", i, slot_val(i), exp); tests_failed++;
            end
        end
        tests_run++;
        if (bus.filled !== 8'hFF || bus.ptr !== 3'd0 || bus.in_ready !== 1'b0 || bus.dbg_state !== 1'b1) begin
            $display("FAIL auto_hold: filled=%h ptr=%0d in_ready=%b state=%b expected FF/0/0/1",
                     bus.filled, bus.ptr, bus.in_ready, bus.dbg_state); tests_failed++;
        end
    endtask

    task automatic test_ack_first_hold();
        logic [31:0] exp_a;
        exp_a = ZERO_ON_ACK ? 32'd0 : 32'd123;
        ack_cycle();
        tests_run++;
        if (bus.filled !== 8'h00 || bus.ptr !== 3'd0 || bus.in_ready !== 1'b1 || bus.frame_done !== 1'b0) begin
            $display("FAIL ack_regs: filled=%h ptr=%0d in_ready=%b frame_done=%b expected 00/0/1/0",
                     bus.filled, bus.ptr, bus.in_ready, bus.frame_done); tests_failed++;
        end
        tests_run++;
        if (bus.a !== exp_a) begin
            $display("FAIL ack_slot_a: got %0d expected %0d", bus.a, exp_a); tests_failed++;
        end
    endtask

    task automatic test_addressed();
        logic [2:0]  sel_t  [10];
        logic [31:0] dat_t  [10];
        logic [7:0]  fil_t  [10];
        logic [31:0] exp_h;
        sel_t = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd3, 3'd3, 3'd2, 3'd1, 3'd0};
        dat_t = '{32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd5, 32'd9, 32'd2, 32'd1, 32'd0};
        fil_t = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hF8, 8'hF8, 8'hFC, 8'hFE, 8'hFF};
        for (int k = 0; k < 10; k++) begin
            send(1'b0, sel_t[k], dat_t[k]);
            tests_run++;
            if (bus.filled !== fil_t[k] || bus.frame_done !== (k == 9)) begin
                $display("FAIL addr_beat%0d: filled=%h frame_done=%b expected %h/%b",
                         k, bus.filled, bus.frame_done, fil_t[k], k == 9); tests_failed++;
            end
        end
        for (int i = 0; i < 8; i++) begin
            tests_run++;
            if (slot_val(i) !== ((i == 3) ? 32'd9 : 32'(i))) begin
                $display("FAIL addr_slot%0d: got %0d expected %0d", i, slot_val(i), (i == 3) ? 9 : i);
                tests_failed++;
            end
        end
        tests_run++;
        if (bus.ptr !== 3'd0) begin
            $display("FAIL addr_ptr: got %0d expected 0", bus.ptr); tests_failed++;
        end
        // Long HOLD with a producer still pushing: nothing may move.
        bus.mode     = 1'b1;
        bus.in_data  = 32'hDEAD_BEEF;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            tests_run++;
            if (bus.in_ready !== 1'b0 || bus.frame_done !== 1'b0 || bus.filled !== 8'hFF || bus.ptr !== 3'd0) begin
                $display("FAIL hold_cycle%0d: in_ready=%b frame_done=%b filled=%h ptr=%0d expected 0/0/FF/0",
                         k, bus.in_ready, bus.frame_done, bus.filled, bus.ptr); tests_failed++;
            end
        end
        bus.in_valid = 1'b0;
        tests_run++;
        if (bus.a !== 32'd0 || bus.h !== 32'd7) begin
            $display("FAIL hold_frozen: a=%h h=%h expected 0/7", bus.a, bus.h); tests_failed++;
        end
        ack_cycle();
        exp_h = ZERO_ON_ACK ? 32'd0 : 32'd7;
        tests_run++;
        if (bus.h !== exp_h || bus.filled !== 8'h00 || bus.in_ready !== 1'b1) begin
            $display("FAIL late_ack: h=%0d filled=%h in_ready=%b expected %0d/00/1",
                     bus.h, bus.filled, bus.in_ready, exp_h); tests_failed++;
        end
    endtask

    task automatic test_clear();
        logic [31:0] exp_e;
        exp_e = ZERO_ON_ACK ? 32'd0 : 32'd4;
        for (int k = 0; k < 4; k++) send(1'b1, 3'd0, 32'd11 + 32'(k));
        tests_run++;
        if (bus.filled !== 8'h0F || bus.ptr !== 3'd4 || bus.d !== 32'd14) begin
            $display("FAIL clear_pre: filled=%h ptr=%0d d=%0d expected 0F/4/14", bus.filled, bus.ptr, bus.d);
            tests_failed++;
        end
        bus.clear    = 1'b1;
        bus.mode     = 1'b1;
        bus.in_data  = 32'd99;
        bus.in_valid = 1'b1;
        #1;
        tests_run++;
        if (bus.in_ready !== 1'b0) begin
            $display("FAIL clear_ready: got %b expected 0", bus.in_ready); tests_failed++;
        end
        @(posedge clk);
        #1;
        bus.clear    = 1'b0;
        bus.in_valid = 1'b0;
        tests_run++;
        if (bus.filled !== 8'h00 || bus.ptr !== 3'd0 || bus.e !== exp_e) begin
            $display("FAIL clear_post: filled=%h ptr=%0d e=%0d expected 00/0/%0d", bus.filled, bus.ptr, bus.e, exp_e);
            tests_failed++;
        end
        send(1'b1, 3'd0, 32'd77);
        tests_run++;
        if (bus.a !== 32'd77 || bus.ptr !== 3'd1 || bus.filled !== 8'h01) begin
            $display("FAIL clear_next: a=%0d ptr=%0d filled=%h expected 77/1/01", bus.a, bus.ptr, bus.filled);
            tests_failed++;
        end
    endtask

    task automatic test_wrap_mixed();
        bus.clear = 1'b1;
        @(posedge clk);
        #1;
        bus.clear = 1'b0;
        send(1'b0, 3'd0, 32'd100);
        send(1'b0, 3'd1, 32'd101);
        tests_run++;
        if (bus.ptr !== 3'd0 || bus.filled !== 8'h03 || bus.a !== 32'd100 || bus.b !== 32'd101) begin
            $display("FAIL mixed_addr: ptr=%0d filled=%h a=%0d b=%0d expected 0/03/100/101",
                     bus.ptr, bus.filled, bus.a, bus.b); tests_failed++;
        end
        for (int k = 0; k < 8; k++) begin
            send(1'b1, 3'd5, 32'd200 + 32'(k));
            if (k == 1) begin
                tests_run++;
                if (bus.ptr !== 3'd2 || bus.filled !== 8'h03 || bus.a !== 32'd200 || bus.b !== 32'd201) begin
                    $display("FAIL mixed_overwrite: ptr=%0d filled=%h a=%0d b=%0d expected 2/03/200/201",
                             bus.ptr, bus.filled, bus.a, bus.b); tests_failed++;
                end
            end
            tests_run++;
            if (bus.frame_done !== (k == 7)) begin
                $display("FAIL mixed_frame_done beat%0d: got %b expected %b", k, bus.frame_done, k == 7);
                tests_failed++;
            end
        end
        tests_run++;
        if (bus.filled !== 8'hFF || bus.ptr !== 3'd0 || bus.h !== 32'd207 || bus.f !== 32'd205) begin
            $display("FAIL wrap_end: filled=%h ptr=%0d h=%0d f=%0d expected FF/0/207/205",
                     bus.filled, bus.ptr, bus.h, bus.f); tests_failed++;
        end
        @(posedge clk);
        #1;
        ack_cycle();
    endtask

    task automatic test_reset_mid_frame();
        for (int k = 0; k < 5; k++) send(1'b1, 3'd0, 32'd1 + 32'(k));
        tests_run++;
        if (bus.e !== 32'd5 || bus.ptr !== 3'd5 || bus.filled !== 8'h1F) begin
            $display("FAIL midrst_pre: e=%0d ptr=%0d filled=%h expected 5/5/1F", bus.e, bus.ptr, bus.filled);
            tests_failed++;
        end
        bus.mode     = 1'b1;
        bus.in_data  = 32'd55;
        bus.in_valid = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) begin
            tests_run++;
            if (slot_val(i) !== 32'd0) begin
                $display("FAIL midrst_slot%0d: got %0d expected 0", i, slot_val(i)); tests_failed++;
            end
        end
        tests_run++;
        if (bus.filled !== 8'h00 || bus.ptr !== 3'd0 || bus.frame_done !== 1'b0) begin
            $display("FAIL midrst_regs: filled=%h ptr=%0d frame_done=%b expected 00/0/0",
                     bus.filled, bus.ptr, bus.frame_done); tests_failed++;
        end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        reset_n      = 1'b1;
        #1;
        tests_run++;
        if (bus.in_ready !== 1'b1 || bus.dbg_state !== 1'b0) begin
            $display("FAIL midrst_ready: in_ready=%b state=%b expected 1/0", bus.in_ready, bus.dbg_state);
            tests_failed++;
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (bus.a !== 32'd0 || bus.filled !== 8'h00) begin
            $display("FAIL midrst_lost_beat: a=%0d filled=%h expected 0/00", bus.a, bus.filled); tests_failed++;
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_auto_fill();
        test_ack_first_hold();
        test_addressed();
        test_clear();
        test_wrap_mixed();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/demux1x8_32bit_seq.md
# demux1x8_32bit_seq

Sequential 1-to-8 word distributor, the inverse of the 8:1 32-bit result multiplexer. It accepts a stream of 32-bit words over a valid/ready handshake and writes each word into one of eight registered output slots, a through h. A slot is chosen either by an explicit 3-bit select or by an internal auto-incrementing pointer. Once all eight slots hold data, it signals frame completion and holds the frame until the consumer acknowledges it. It sits between a single ALU result path and the eight-operand consumers fed by the mux, such as operand banks and the testbench scoreboards.

## Interface
Parameters:
- none (width fixed at 32 bits, depth fixed at 8 slots)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- in_data  input  32  word to be written
- in_sel  input  3  target slot for addressed mode (0=a … 7=h)
- mode  input  1  0 = addressed (use in_sel), 1 = auto (use ptr)
- in_valid  input  1  producer has a word on in_data
- in_ready  output  1  block accepts a word this cycle
- clear  input  1  synchronous frame abort: empties all slots and resets ptr
- frame_ack  input  1  consumer has taken the completed frame
- a, b, c, d, e, f, g, h  output  32 each  slot registers 0..7
- filled  output  8  bit i set when slot i has been written in the current frame
- ptr  output  3  next slot for auto mode
- frame_done  output  1  one-cycle pulse on the first cycle of HOLD

## Operation
- There are two states. FILL accepts words; HOLD freezes the frame.
- Handshake:
  - in_ready = (state==FILL) && !clear.
  - A beat is accepted when in_valid && in_ready.
  - in_ready has no combinational path from in_valid.
- Slot selection for an accepted beat:
  - Target = mode ? ptr : in_sel.
  - mode is sampled per beat, so mixing modes within a frame is legal.
- Write: target slot register <= in_data, and filled[target] <= 1.
  - Writing an already-filled slot overwrites its data; filled is unchanged.
- Pointer:
  - ptr increments by 1 mod 8 only on accepted auto-mode beats (7 wraps to 0).
  - Addressed beats leave ptr unchanged.
- FILL→HOLD: taken at the edge where filled would become 8'hFF.
- In HOLD:
  - in_ready = 0.
  - Slots, filled and ptr are frozen.
- HOLD→FILL: taken on frame_ack. On that edge, filled <= 0 and ptr <= 0.
  - Slot data is retained unless the macro below is defined.
- frame_ack in FILL is ignored.
- clear (either state):
  - filled <= 0, ptr <= 0, state <= FILL, slot data retained.
  - clear has priority over frame_ack and over any write.
- Reset values: state FILL, a..h = 0, filled = 0, ptr = 0, frame_done = 0, in_ready = 1 once reset_n deasserts.

## Timing
- Write latency is 1 cycle: a beat accepted at edge N is visible on its slot and filled after edge N.
- frame_done:
  - Registered; high for exactly the one cycle following the completing edge, i.e. the first HOLD cycle.
  - It is not re-asserted however long HOLD lasts.
- frame_ack asserted in the first HOLD cycle is legal. The frame then lasts 1 cycle and in_ready rises the next cycle.
- Throughput is one beat per cycle in FILL. The minimum frame is 8 beats, 1 HOLD cycle and the ack, so 9 cycles per frame.
- Asynchronous reset mid-frame immediately forces all reset values; a pending beat is lost.
- clear asserted in the same cycle as in_valid: in_ready is 0, so nothing is accepted.

## Configuration
- DEMUX_ZERO_ON_ACK_EN:
  - Defined: the HOLD→FILL transition on frame_ack also zeroes a..h. clear still retains data.
  - Undefined: a..h keep their last values across frames until overwritten.

## Test plan
- **Auto fill.** After reset, in mode=1, send 123, 456, 789, 101112, 131415, 161718, 192021, 222324 on consecutive cycles.
  - a..h equal those values in order.
  - frame_done pulses once, one cycle after the 8th beat.
  - in_ready is 0 until frame_ack.
- **Addressed reverse order.** In mode=0, in_sel=7..0 with data 7..0: slot i = i, and filled goes 80,C0,…,FF.
  - Then write in_sel=3 twice (data 5 then 9) before completion: d=9 and no early frame_done.
- **Ack behaviour.** frame_ack in the first HOLD cycle: next cycle filled=0, ptr=0, in_ready=1.
  - Slot a still 123, or 0 when DEMUX_ZERO_ON_ACK_EN is defined.
- **Clear priority.** After 4 auto beats, assert clear with in_valid=1: no write, filled=0, ptr=0.
  - The next auto beat lands in a.
- **Wrap and mixed mode.**
  - Setup: addressed writes to slots 0 and 1, then auto beats.
  - ptr starts at 0, overwrites a and b, and advances through h.
  - After slot h is written, filled=FF and frame_done fires; ptr has wrapped to 0.
- **Reset mid-frame.** Pulse reset_n low after 5 beats: all slots 0, filled 0, ptr 0 and frame_done 0 asynchronously, and in_ready=1 after release.
